// File: rtl/tinyspu_pkg.sv
// Shared types and defaults for the tinyspu pixel pipeline blocks.
package tinyspu_pkg;

  localparam int unsigned PIX_W_DEFAULT = 4;

  typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

  typedef enum logic [0:0] {
    PASS0 = 1'b0,
    PASS1 = 1'b1
  } unpool_state_t;

endpackage

// File: rtl/line_buf_sp.sv
// Single-port-write line buffer: synchronous write, asynchronous indexed read.
module line_buf_sp #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents are always overwritten by the next row before being read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/focal_unpool_row_stream.sv
// 2x nearest-neighbour upsampler: each pooled row is emitted as two rows,
// every pixel duplicated horizontally; the second row replays the line buffer.
module focal_unpool_row_stream
  import tinyspu_pkg::*;
#(
  parameter int unsigned ROW_LEN = 4,
  parameter int unsigned PIX_W   = PIX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int unsigned      IDX_W    = $clog2(ROW_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROW_LEN - 1);

  unpool_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] wr_addr;
  logic             dup;
  logic             hold_v;
  logic [PIX_W-1:0] hold;
  logic [PIX_W-1:0] rd_data;
  logic             last_idx;
  logic             can_take;
  logic             in_fire;
  logic             out_fire;
  logic             wr_en;

  always_comb begin
    last_idx  = (idx == IDX_LAST);
    can_take  = (state == PASS0) && (!hold_v || (out_ready && dup && !last_idx));
    in_ready  = rst_n && can_take;
    in_fire   = in_valid && in_ready;
    out_valid = (state == PASS1) || hold_v;
    out_data  = (state == PASS1) ? rd_data : hold;
    out_last  = out_valid && dup && last_idx;
    out_fire  = out_valid && out_ready;
    wr_en     = in_fire && !clr;
    // An accept while hold is full coincides with idx stepping, so it lands one slot ahead.
    wr_addr   = hold_v ? (idx + IDX_W'(1)) : idx;
  end

  line_buf_sp #(
    .DEPTH(ROW_LEN),
    .WIDTH(PIX_W)
  ) u_line_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(in_data),
    .rd_addr(idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PASS0;
      idx    <= '0;
      dup    <= 1'b0;
      hold_v <= 1'b0;
      hold   <= '0;
    end else if (clr) begin
      state  <= PASS0;
      idx    <= '0;
      dup    <= 1'b0;
      hold_v <= 1'b0;
      hold   <= '0;
    end else begin
      if (out_fire) begin
        dup <= ~dup;
        if (dup) begin
          hold_v <= 1'b0;
          if (last_idx) begin
            idx   <= '0;
            state <= (state == PASS0) ? PASS1 : PASS0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
      // A same-cycle accept refills hold, overriding the release above.
      if (in_fire) begin
        hold   <= in_data;
        hold_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_focal_unpool_row_stream.sv
// Directed bench for focal_unpool_row_stream (ROW_LEN=4, PIX_W=4).
module tb_focal_unpool_row_stream;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  logic [3:0] got_d[$];
  logic       got_l[$];
  int         got_c[$];
  int         acc_c[$];
  logic [3:0] exp_d[$];
  logic       exp_l[$];
  int         ir_late;
  int         n_stall;

  focal_unpool_row_stream #(
    .ROW_LEN(4),
    .PIX_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stream: each row twice, each pixel twice, last on the 2nd copy of pixel 3.
  task automatic build_exp(input logic [3:0] px [8], input int n_rows);
    exp_d.delete();
    exp_l.delete();
    for (int r = 0; r < n_rows; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int i = 0; i < 4; i++)
          for (int d = 0; d < 2; d++) begin
            exp_d.push_back(px[r*4+i]);
            exp_l.push_back((i == 3) && (d == 1));
          end
  endtask

  // Drives n_px pixels (one offer every gap cycles) and records output transfers.
  task automatic stream(input logic [3:0] px [8], input int n_px, input int gap,
                        input bit toggle, input int n_out, input int budget);
    int         p;
    bit         acc;
    bit         stall;
    logic [3:0] sd;
    logic       sl;
    p = 0; acc = 1'b0; stall = 1'b0; sd = '0; sl = 1'b0;
    ir_late = 0; n_stall = 0;
    got_d.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
    for (int cyc = 0; cyc < budget && got_d.size() < n_out; cyc++) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (acc || !in_valid) begin
        if (p < n_px && (cyc % gap) == 0) begin
          in_valid = 1'b1;
          in_data  = px[p];
        end else begin
          in_valid = 1'b0;
        end
      end
      acc = 1'b0;
      @(negedge clk);
      if (stall) begin
        checks++;
        n_stall++;
        if (out_valid !== 1'b1 || out_data !== sd || out_last !== sl) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   cyc, out_valid, out_data, out_last, sd, sl);
        end
      end
      stall = out_valid && !out_ready;
      sd    = out_data;
      sl    = out_last;
      if (p == n_px && in_ready) ir_late++;
      if (in_valid && in_ready) begin
        acc = 1'b1;
        p++;
        acc_c.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_c.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, in_ready} !== 3'b000 || out_data !== 4'h0) begin
      errors++;
      $display("FAIL reset_outs got v=%b l=%b r=%b d=%h exp 0 0 0 0",
               out_valid, out_last, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_row();
    logic [3:0] row [8];
    row = '{4'h3, 4'h7, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    build_exp(row, 1);
    stream(row, 4, 1, 1'b0, 16, 40);
    checks++;
    if (got_d.size() != 16) begin
      errors++;
      $display("FAIL row1_count got %0d exp 16", got_d.size());
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL row1_seq[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
    checks++;
    if (got_c[0] - acc_c[0] != 1) begin
      errors++;
      $display("FAIL row1_latency got %0d exp 1", got_c[0] - acc_c[0]);
    end
    checks++;
    if (got_c[15] - acc_c[0] != 16) begin
      errors++;
      $display("FAIL row1_span got %0d exp 16", got_c[15] - acc_c[0]);
    end
    checks++;
    if (ir_late != 0) begin
      errors++;
      $display("FAIL row1_pass1_ready got %0d cycles exp 0", ir_late);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] row [8];
    row = '{4'h2, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    build_exp(row, 2);
    stream(row, 8, 1, 1'b0, 32, 80);
    checks++;
    if (got_d.size() != 32) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 32", got_d.size());
    end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL b2b_seq[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
    checks++;
    if (acc_c[4] != got_c[15] + 1) begin
      errors++;
      $display("FAIL b2b_row2_accept got cyc %0d exp %0d", acc_c[4], got_c[15] + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] row [8];
    row = '{4'h5, 4'h5, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    build_exp(row, 1);
    stream(row, 4, 1, 1'b1, 16, 60);
    checks++;
    if (got_d.size() != 16) begin
      errors++;
      $display("FAIL bp_count got %0d exp 16", got_d.size());
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL bp_seq[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
    checks++;
    if (n_stall < 4) begin
      errors++;
      $display("FAIL bp_stalls got %0d exp >=4", n_stall);
    end
  endtask

  task automatic test_starvation();
    logic [3:0] row [8];
    row = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    build_exp(row, 1);
    stream(row, 4, 4, 1'b0, 16, 60);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL starve_seq[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
    checks++;
    if (got_c[2] - acc_c[0] != 5) begin
      errors++;
      $display("FAIL starve_gap got cyc %0d exp 5", got_c[2] - acc_c[0]);
    end
    checks++;
    if (got_c[15] - got_c[8] != 7 || got_c[15] - acc_c[0] != 22) begin
      errors++;
      $display("FAIL starve_pass1 got span %0d end %0d exp 7 22",
               got_c[15] - got_c[8], got_c[15] - acc_c[0]);
    end
  endtask

  task automatic test_clr();
    logic [3:0] row [8];
    int         stray;
    row = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    stream(row, 2, 1, 1'b0, 3, 20);
    checks++;
    if (got_d.size() != 3 || got_d[0] !== 4'h1 || got_d[1] !== 4'h1 || got_d[2] !== 4'h2) begin
      errors++;
      $display("FAIL clr_prefix got n=%0d %h %h %h exp 3 1 1 2", got_d.size(), got_d[0], got_d[1], got_d[2]);
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_idle got v=%b l=%b r=%b exp 0 0 1", out_valid, out_last, in_ready);
    end
    row = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    build_exp(row, 1);
    stream(row, 4, 1, 1'b0, 16, 40);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL clr_seq[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL clr_residue got %0d extra valid cycles exp 0", stray);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] row [8];
    row = '{4'h9, 4'h3, 4'h5, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
    stream(row, 4, 1, 1'b0, 11, 40);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, in_ready} !== 3'b000 || out_data !== 4'h0) begin
      errors++;
      $display("FAIL arst_immediate got v=%b l=%b r=%b d=%h exp 0 0 0 0",
               out_valid, out_last, in_ready, out_data);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
    end
    row = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
    build_exp(row, 1);
    stream(row, 4, 1, 1'b0, 16, 40);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        errors++;
        $display("FAIL arst_seq[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_starvation();
    test_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
